mandelbrot_calc: RTL and testbench
==================================

MANDELBROT_CALC -- requirements
Module: mandelbrot_calc

Interface
REQ-001 Parameter FPW, default 27, fixed-point word width, format 1 sign / 4 integer / FPW-5 fraction bits (FP_F = FPW-5).
REQ-002 Parameter AW, default 12, pixel address width.
REQ-003 Parameter IW, default 8, iteration counter width.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 clk_en  input  1  clock enable; no state changes and no handshake transfers while low.
REQ-007 max_iter  input  IW  iteration limit, sampled at each input transfer.
REQ-008 in_vld  input  1  coordinate valid from the coordinate generator.
REQ-009 in_rdy  output  1  ready to accept a coordinate (ack to the generator).
REQ-010 in_x, in_y  input  FPW each  signed c = (cx, cy).
REQ-011 in_adr  input  AW  pixel address accompanying the coordinate.
REQ-012 out_vld  output  1  result valid.
REQ-013 out_rdy  input  1  downstream ready.
REQ-014 out_iter  output  IW  completed iteration count.
REQ-015 out_esc  output  1  1 = point escaped, 0 = limit reached.
REQ-016 out_adr  output  AW  address of the result.

Function
REQ-017 FSM states IDLE, ITER, OUT; in_rdy = (state==IDLE); out_vld = (state==OUT); both decoded from registered state only.
REQ-018 Input transfer: clk_en & in_vld & in_rdy at an edge; latch cx, cy, adr, max_iter; set zx=zy=0, iter=0; go to ITER.
REQ-019 In ITER, each step: xx=(zx*zx)>>>FP_F, yy=(zy*zy)>>>FP_F, xy=(zx*zy)>>>FP_F; full 2*FPW signed products, arithmetic shift, xx/yy/xy kept untruncated (2*FPW-FP_F bits).
REQ-020 Escape test: (xx+yy) > 4.0 (4<<FP_F), compared at untruncated width; equality does not escape.
REQ-021 Priority per step: escape -> OUT with out_esc=1; else iter==max_iter -> OUT with out_esc=0; else zx=xx-yy+cx, zy=2*xy+cy (truncated to FPW, two's-complement wrap), iter=iter+1.
REQ-022 out_iter = iter at the step that entered OUT; out_adr = latched adr; outputs stable while out_vld high and out_rdy low.
REQ-023 Output transfer: clk_en & out_vld & out_rdy -> IDLE; a new input is accepted no earlier than the following edge.
REQ-024 max_iter=0: first step enters OUT with out_iter=0, out_esc=0 (escape false since z=0).
REQ-025 Latency without macro: escaped point leaves ITER out_iter+1 enabled edges after acceptance; non-escaped after max_iter+1 edges.
REQ-026 in_vld/in_x/in_y/in_adr changes outside IDLE are ignored.

Reset
REQ-027 rst high: state=IDLE, in_rdy=1, out_vld=0, out_iter=0, out_esc=0, out_adr=0, zx=zy=cx=cy=0, iter=0, immediately and independent of clk_en.
REQ-028 rst asserted mid-ITER or in OUT aborts the pixel with no result; first transfer after release starts a fresh pixel.

Configuration
REQ-029 Macro MANDELBROT_CALC_MULREG_EN defined: products xx/yy/xy registered; each iteration step takes 2 enabled edges (multiply, then test/update); escape/limit/update semantics identical; latency per REQ-025 doubles for the ITER portion.
REQ-030 Macro undefined: multiply, test and update complete in one enabled edge per step.

Verification
REQ-031 c=(0,0), max_iter=255 -> out_iter=255, out_esc=0, out_adr echoed, out_vld 256 edges after acceptance (512 with macro).
REQ-032 c=(1.0,0) -> z: 0,1,2,5; out_iter=3, out_esc=1, out_vld after 4 ITER edges.
REQ-033 c=(-2.0,0), max_iter=20 -> |z|^2 sits at exactly 4.0, no escape; out_iter=20, out_esc=0.
REQ-034 c=(2.0,0), out_rdy held low 10 cycles -> out_iter=2, out_esc=1; outputs stable, in_rdy=0 throughout; one edge with out_rdy=1 -> IDLE.
REQ-035 clk_en toggled 50% during c=(1,0) -> identical result, ITER edge count counted only on enabled edges.
REQ-036 rst pulse during ITER of c=(0,0) -> out_vld never rises for that pixel; next c=(1,0) gives out_iter=3.

Source files
------------

// File: rtl/mandelbrot_calc.sv
// ============================================================================
// Module      : mandelbrot_calc
// Description : Iterates z = z^2 + c per pixel and reports escape and iteration
//               count. Define MANDELBROT_CALC_MULREG_EN to register the products.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mandelbrot_calc #(
  parameter int FPW = 27,
  parameter int AW  = 12,
  parameter int IW  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic [IW-1:0]         max_iter,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic signed [FPW-1:0] in_x,
  input  logic signed [FPW-1:0] in_y,
  input  logic [AW-1:0]         in_adr,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [IW-1:0]         out_iter,
  output logic                  out_esc,
  output logic [AW-1:0]         out_adr
);

  localparam int c_fp_f = FPW - 5;
  localparam int c_pw   = 2 * FPW;
  localparam int c_qw   = c_pw - c_fp_f;
  localparam logic signed [c_qw:0] c_four =
    {{(c_qw - 2 - c_fp_f){1'b0}}, 3'b100, {c_fp_f{1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, OUT = 2'd2} state_t;

  state_t                r_state, w_state_nx;
  logic signed [FPW-1:0] r_zx, r_zy, r_cx, r_cy;
  logic [IW-1:0]         r_iter, r_max;
  logic [AW-1:0]         r_adr;
  logic                  r_esc;

  logic signed [c_pw-1:0] w_zx_ext, w_zy_ext;
  logic signed [c_pw-1:0] w_pxx, w_pyy, w_pxy;
  logic signed [c_pw-1:0] w_mxx, w_myy, w_mxy;
  logic signed [c_qw-1:0] w_xx, w_yy, w_xy;
  logic signed [c_qw:0]   w_sum;
  logic signed [FPW-1:0]  w_zx_nx, w_zy_nx;
  logic                   w_step, w_esc, w_limit, w_accept;
  logic                   w_unused;

  assign w_zx_ext = {{(c_pw - FPW){r_zx[FPW-1]}}, r_zx};
  assign w_zy_ext = {{(c_pw - FPW){r_zy[FPW-1]}}, r_zy};
  assign w_pxx    = w_zx_ext * w_zx_ext;
  assign w_pyy    = w_zy_ext * w_zy_ext;
  assign w_pxy    = w_zx_ext * w_zy_ext;

`ifdef MANDELBROT_CALC_MULREG_EN
  // Two-phase step: phase 0 captures the products, phase 1 tests and updates.
  logic signed [c_pw-1:0] r_pxx, r_pyy, r_pxy;
  logic                   r_phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pxx   <= '0;
      r_pyy   <= '0;
      r_pxy   <= '0;
      r_phase <= 1'b0;
    end else if (clk_en) begin
      r_pxx   <= w_pxx;
      r_pyy   <= w_pyy;
      r_pxy   <= w_pxy;
      r_phase <= (r_state == ITER) && !r_phase;
    end
  end

  assign w_mxx  = r_pxx;
  assign w_myy  = r_pyy;
  assign w_mxy  = r_pxy;
  assign w_step = (r_state == ITER) && r_phase;
`else
  assign w_mxx  = w_pxx;
  assign w_myy  = w_pyy;
  assign w_mxy  = w_pxy;
  assign w_step = (r_state == ITER);
`endif

  // Dropping the low fraction bits is the arithmetic shift; the rest is kept.
  assign w_xx  = w_mxx[c_pw-1:c_fp_f];
  assign w_yy  = w_myy[c_pw-1:c_fp_f];
  assign w_xy  = w_mxy[c_pw-1:c_fp_f];
  assign w_sum = {w_xx[c_qw-1], w_xx} + {w_yy[c_qw-1], w_yy};
  assign w_esc = (w_sum > c_four);
  assign w_limit = (r_iter == r_max);

  // Only the low FPW bits survive the wrap, so the adders stay FPW wide.
  assign w_zx_nx = w_xx[FPW-1:0] - w_yy[FPW-1:0] + r_cx;
  assign w_zy_nx = {w_xy[FPW-2:0], 1'b0} + r_cy;

  assign w_unused = ^{w_mxx[c_fp_f-1:0], w_myy[c_fp_f-1:0], w_mxy[c_fp_f-1:0],
                      w_xy[c_qw-1:FPW-1]};

  assign w_accept = (r_state == IDLE) && in_vld;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (in_vld) w_state_nx = ITER;
      ITER:    if (w_step && (w_esc || w_limit)) w_state_nx = OUT;
      OUT:     if (out_rdy) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_zx    <= '0;
      r_zy    <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_iter  <= '0;
      r_max   <= '0;
      r_adr   <= '0;
      r_esc   <= 1'b0;
    end else if (clk_en) begin
      r_state <= w_state_nx;
      if (w_accept) begin
        r_cx   <= in_x;
        r_cy   <= in_y;
        r_adr  <= in_adr;
        r_max  <= max_iter;
        r_zx   <= '0;
        r_zy   <= '0;
        r_iter <= '0;
        r_esc  <= 1'b0;
      end else if (w_step) begin
        if (w_esc || w_limit) begin
          r_esc <= w_esc;
        end else begin
          r_zx   <= w_zx_nx;
          r_zy   <= w_zy_nx;
          r_iter <= r_iter + 1'b1;
        end
      end
    end
  end

  assign in_rdy   = (r_state == IDLE);
  assign out_vld  = (r_state == OUT);
  assign out_iter = r_iter;
  assign out_esc  = r_esc;
  assign out_adr  = r_adr;

endmodule

`default_nettype wire

// File: tb/tb_mandelbrot_calc.sv
// ============================================================================
// Module      : tb_mandelbrot_calc
// Description : Directed and random pixels checked against an escape-time model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mandelbrot_calc;

  localparam int FPW = 27;
  localparam int AW  = 12;
  localparam int IW  = 8;
  localparam int FP_F = FPW - 5;
  localparam longint ONE = longint'(1) << FP_F;
`ifdef MANDELBROT_CALC_MULREG_EN
  localparam int MF = 2;
`else
  localparam int MF = 1;
`endif

  logic                  clk, rst, clk_en, in_vld, in_rdy, out_vld, out_rdy, out_esc;
  logic [IW-1:0]         max_iter, out_iter;
  logic signed [FPW-1:0] in_x, in_y;
  logic [AW-1:0]         in_adr, out_adr;

  int n_cmp = 0;
  int n_bad = 0;

  mandelbrot_calc #(.FPW(FPW), .AW(AW), .IW(IW)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .max_iter(max_iter),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_x(in_x), .in_y(in_y), .in_adr(in_adr),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_iter(out_iter),
    .out_esc(out_esc), .out_adr(out_adr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint wrap(input longint v);
    logic signed [FPW-1:0] t;
    t = v[FPW-1:0];
    return longint'(t);
  endfunction

  // Escape-time reference in plain integer arithmetic.
  task automatic model(input longint cx, input longint cy, input int mi,
                       output int it, output bit esc);
    longint zx, zy, xx, yy, xy;
    bit done;
    zx = 0; zy = 0; it = 0; esc = 0; done = 0;
    for (int s = 0; s <= mi + 1 && !done; s++) begin
      xx = (zx * zx) >>> FP_F;
      yy = (zy * zy) >>> FP_F;
      xy = (zx * zy) >>> FP_F;
      if (xx + yy > 4 * ONE) begin
        esc = 1; done = 1;
      end else if (it == mi) begin
        done = 1;
      end else begin
        zx = wrap(xx - yy + cx);
        zy = wrap(2 * xy + cy);
        it++;
      end
    end
  endtask

  task automatic run_pixel(input string tag, input longint cx, input longint cy,
                           input int mi, input bit toggle, input int hold);
    int  exp_it, edges, lat;
    bit  exp_esc, done;
    logic [AW-1:0] adr;
    model(cx, cy, mi, exp_it, exp_esc);
    lat = MF * (exp_esc ? exp_it + 1 : mi + 1);
    adr = AW'($urandom);
    clk_en = 1'b1; out_rdy = 1'b0;
    chk({tag, ".in_rdy_idle"}, in_rdy, 1);
    in_x = cx[FPW-1:0]; in_y = cy[FPW-1:0]; in_adr = adr; max_iter = IW'(mi);
    in_vld = 1'b1;
    @(posedge clk); #1;
    edges = 0; done = 0;
    for (int k = 0; k < 3000 && !done; k++) begin
      clk_en   = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      in_vld   = 1'($urandom);
      in_x     = FPW'($urandom);
      in_adr   = AW'($urandom);
      max_iter = IW'($urandom);
      @(posedge clk);
      if (clk_en) edges++;
      #1;
      if (out_vld) done = 1;
    end
    clk_en = 1'b1;
    chk({tag, ".done"}, done, 1);
    chk({tag, ".latency"}, edges, lat);
    chk({tag, ".iter"}, out_iter, exp_it);
    chk({tag, ".esc"}, out_esc, exp_esc);
    chk({tag, ".adr"}, out_adr, adr);
    chk({tag, ".in_rdy_busy"}, in_rdy, 0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, ".hold_vld"}, out_vld, 1);
      chk({tag, ".hold_rdy"}, in_rdy, 0);
      chk({tag, ".hold_iter"}, out_iter, exp_it);
      chk({tag, ".hold_esc"}, out_esc, exp_esc);
      chk({tag, ".hold_adr"}, out_adr, adr);
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0;
    chk({tag, ".released"}, out_vld, 0);
    chk({tag, ".back_idle"}, in_rdy, 1);
  endtask

  initial begin
    int  seen;
    longint rx, ry;
    rst = 1'b1; clk_en = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
    in_x = '0; in_y = '0; in_adr = '0; max_iter = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_rdy", in_rdy, 1);
    chk("rst.out_vld", out_vld, 0);
    chk("rst.out_iter", out_iter, 0);
    chk("rst.out_esc", out_esc, 0);
    chk("rst.out_adr", out_adr, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_pixel("c00", 0, 0, 255, 0, 2);
    run_pixel("c10", ONE, 0, 255, 0, 0);
    run_pixel("cm20", -2 * ONE, 0, 20, 0, 1);
    run_pixel("c20", 2 * ONE, 0, 255, 0, 10);
    run_pixel("c10_en", ONE, 0, 255, 1, 0);
    run_pixel("max0", ONE / 3, -ONE / 5, 0, 0, 0);

    // Abort a pixel mid-iteration with an asynchronous reset pulse.
    clk_en = 1'b1; in_x = '0; in_y = '0; in_adr = 12'h5a5; max_iter = 8'd255;
    in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst.in_rdy", in_rdy, 1);
    chk("arst.out_vld", out_vld, 0);
    chk("arst.out_adr", out_adr, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (600) begin
      @(posedge clk); #1;
      if (out_vld) seen++;
    end
    chk("arst.no_result", seen, 0);
    run_pixel("post_rst", ONE, 0, 255, 0, 0);

    for (int r = 0; r < 8; r++) begin
      rx = longint'($urandom_range(0, 4 * ONE)) - (5 * ONE / 2);
      ry = longint'($urandom_range(0, 3 * ONE)) - (3 * ONE / 2);
      run_pixel($sformatf("rnd%0d", r), rx, ry, int'($urandom_range(0, 60)),
                bit'(r[0]), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
